// File: rtl/fetch_if.sv
// fetch_if: fetch-stage control bundle; master = controller (takes branch_taken/hazard_stall/imem_ack, drives imem_req/PCSrc/stallF/stallD/flushD/fetch_err/stall_cycles)
interface fetch_if #(parameter int DATA_WIDTH = 16);
  logic branch_taken, hazard_stall, imem_ack;
  logic imem_req, PCSrc, stallF, stallD, flushD, fetch_err;
  logic [DATA_WIDTH-1:0] stall_cycles;
  modport master(
    input  branch_taken, hazard_stall, imem_ack,
    output imem_req, PCSrc, stallF, stallD, flushD, fetch_err, stall_cycles
  );
  modport slave(
    output branch_taken, hazard_stall, imem_ack,
    input  imem_req, PCSrc, stallF, stallD, flushD, fetch_err, stall_cycles
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencing FSM over a req/ack imem; ports clk, rst (async high), bus (fetch_if.master: hazard/branch/ack in, stall/flush/PCSrc/req/err/stall count out)
module fetch_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 15
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, SQUASH, ERROR} state_t;
  state_t state, state_n;
  logic [7:0] wait_cnt;
  logic [DATA_WIDTH-1:0] sc;
  logic err, br, hz, ack, active, timeout, stall_inc;
  logic req, pcsrc, stf, std, fld;
  assign br        = bus.branch_taken;
  assign hz        = bus.hazard_stall;
  assign ack       = bus.imem_ack;
  assign active    = state == FETCH || state == SQUASH;
  assign timeout   = active && !ack && wait_cnt == 8'(MAX_WAIT);
  assign stall_inc = (state == FETCH && !ack && !br) || state == SQUASH;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb
    state_n = timeout           ? ERROR :
              state == IDLE     ? FETCH :
              state == FETCH    ? (br && !ack ? SQUASH : FETCH) :
              state == SQUASH   ? (ack ? FETCH : SQUASH) : ERROR;
  always_comb begin
    req   = 1'b0;
    pcsrc = 1'b0;
    stf   = 1'b1;
    std   = 1'b0;
    fld   = 1'b1;
    case (state)
      FETCH: begin
        req   = 1'b1;
        pcsrc = br;
        stf   = br ? 1'b0 : hz ? 1'b1 : !ack;
        std   = !br && hz;
        fld   = br ? 1'b1 : hz ? 1'b0 : !ack;
      end
      SQUASH: begin
        pcsrc = br;
        stf   = !br;
      end
      ERROR: std = 1'b1;
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
      sc       <= '0;
    end else begin
      wait_cnt <= (state == IDLE || ack || (state == FETCH && br)) ? '0 :
                  active ? wait_cnt + 8'd1 : wait_cnt;
      err      <= state_n == ERROR;
      if (stall_inc && sc != '1) sc <= sc + DATA_WIDTH'(1);
    end
  assign bus.imem_req     = req;
  assign bus.PCSrc        = pcsrc;
  assign bus.stallF       = stf;
  assign bus.stallD       = std;
  assign bus.flushD       = fld;
  assign bus.fetch_err    = err;
  assign bus.stall_cycles = sc;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl with a small counter to reach stall_cycles saturation
module tb_fetch_ctrl;
  localparam int DW = 4;
  localparam int MW = 4;
  localparam logic [4:0] O_IDLE = 5'b00101;
  localparam logic [4:0] O_ACC  = 5'b10000;
  localparam logic [4:0] O_WAIT = 5'b10101;
  localparam logic [4:0] O_BR   = 5'b11001;
  localparam logic [4:0] O_HZ   = 5'b10110;
  localparam logic [4:0] O_SQ   = 5'b00101;
  localparam logic [4:0] O_SQB  = 5'b01001;
  localparam logic [4:0] O_ERR  = 5'b00111;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_if #(.DATA_WIDTH(DW)) bus();
  fetch_ctrl #(.DATA_WIDTH(DW), .MAX_WAIT(MW)) dut(.clk(clk), .rst(rst), .bus(bus));
  logic [4:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] outs();
    return {bus.imem_req, bus.PCSrc, bus.stallF, bus.stallD, bus.flushD};
  endfunction
  task automatic step(input logic br, input logic hz, input logic ack, input logic [4:0] exp, input string tag);
    bus.branch_taken = br;
    bus.hazard_stall = hz;
    bus.imem_ack     = ack;
    exp_q.push_back(exp);
    @(negedge clk);
    check(tag, 32'(outs()), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.branch_taken = 1'b0;
    bus.hazard_stall = 1'b0;
    bus.imem_ack     = 1'b0;
    #3;
    check("rst_outs", 32'(outs()), 32'(O_IDLE));
    check("rst_err", 32'(bus.fetch_err), 0);
    check("rst_sc", 32'(bus.stall_cycles), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    step(0, 0, 0, O_IDLE, "idle");
    for (int i = 0; i < 4; i++) step(0, 0, 1, O_ACC, "zw_acc");
    check("zw_sc", 32'(bus.stall_cycles), 0);
    do_reset();
    step(0, 0, 0, O_IDLE, "idle2");
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, O_WAIT, "w2_wait1");
      step(0, 0, 0, O_WAIT, "w2_wait2");
      step(0, 0, 1, O_ACC, "w2_acc");
      if (i == 0) check("w2_sc1", 32'(bus.stall_cycles), 2);
    end
    check("w2_sc2", 32'(bus.stall_cycles), 4);
    step(0, 0, 0, O_WAIT, "br_wait");
    step(1, 0, 0, O_BR, "br_redirect");
    step(0, 0, 0, O_SQ, "br_squash");
    step(0, 0, 1, O_SQ, "br_stale_ack");
    step(0, 0, 1, O_ACC, "br_refetch");
    check("br_sc", 32'(bus.stall_cycles), 7);
    step(0, 0, 0, O_WAIT, "sqb_wait");
    step(1, 0, 0, O_BR, "sqb_redirect");
    step(1, 0, 0, O_SQB, "sqb_branch_in_squash");
    step(0, 0, 1, O_SQ, "sqb_stale_ack");
    step(0, 0, 1, O_ACC, "sqb_refetch");
    check("sqb_sc", 32'(bus.stall_cycles), 10);
    step(0, 1, 0, O_HZ, "hz_c1");
    step(0, 1, 1, O_HZ, "hz_c2_ack");
    step(0, 1, 0, O_HZ, "hz_c3");
    step(0, 0, 1, O_ACC, "hz_refetch");
    check("hz_sc", 32'(bus.stall_cycles), 12);
    step(1, 1, 1, O_BR, "all3");
    step(0, 0, 1, O_ACC, "all3_stay_fetch");
    check("all3_sc", 32'(bus.stall_cycles), 12);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, O_WAIT, "to_wait");
      if (i == 3) check("to_err_early", 32'(bus.fetch_err), 0);
    end
    check("to_err", 32'(bus.fetch_err), 1);
    check("to_sc_sat", 32'(bus.stall_cycles), 15);
    step(0, 0, 0, O_ERR, "err_hold");
    step(1, 1, 1, O_ERR, "err_ignore");
    check("err_sticky", 32'(bus.fetch_err), 1);
    check("err_sc", 32'(bus.stall_cycles), 15);
    do_reset();
    step(0, 0, 0, O_IDLE, "idle3");
    step(0, 0, 1, O_ACC, "post_err_acc");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
